// File: rtl/dispatch_queue.sv
// Decoded-instruction FIFO between fetch and RoB/RS/LSB. Issues the head strictly in order,
// stalling only on the units that head needs, and captures operands with CDB forwarding.
module dispatch_queue #(
   parameter int RoB_WIDTH       = 3,
   parameter int QUEUE_DEPTH_LOG = 2,
   parameter int CDB_PORTS       = 2
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             rdy_in,
   input  logic                             flush_signal,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [31:0]                      in_pc,
   input  logic [31:0]                      in_imm,
   input  logic [6:0]                       in_opcode,
   input  logic [4:0]                       in_rs1,
   input  logic [4:0]                       in_rs2,
   input  logic [4:0]                       in_rd,
   input  logic                             in_predict,
   output logic [4:0]                       RF_rs1,
   output logic [4:0]                       RF_rs2,
   input  logic [RoB_WIDTH:0]               RF_Qj,
   input  logic [RoB_WIDTH:0]               RF_Qk,
   input  logic [31:0]                      RF_Vj,
   input  logic [31:0]                      RF_Vk,
   input  logic [CDB_PORTS-1:0]             cdb_valid,
   input  logic [CDB_PORTS*RoB_WIDTH-1:0]   cdb_tag,
   input  logic [CDB_PORTS*32-1:0]          cdb_data,
   input  logic                             RoB_isFull,
   input  logic                             RS_isFull,
   input  logic                             LSB_isFull,
   input  logic [RoB_WIDTH-1:0]             RoB_newEntryIndex,
   output logic                             RoB_newEntry_en,
   output logic                             RS_newEntry_en,
   output logic                             LSB_newEntry_en,
   output logic                             RF_newEntry_en,
   output logic [RoB_WIDTH-1:0]             out_robIndex,
   output logic [6:0]                       out_opcode,
   output logic [4:0]                       out_rd,
   output logic [31:0]                      out_pc,
   output logic [31:0]                      out_next_pc,
   output logic [31:0]                      out_imm,
   output logic [31:0]                      out_Vj,
   output logic [31:0]                      out_Vk,
   output logic [RoB_WIDTH:0]               out_Qj,
   output logic [RoB_WIDTH:0]               out_Qk,
   output logic                             out_predict,
   output logic                             out_already_ready,
   output logic [31:0]                      out_ready_data
);

   localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
   localparam logic [RoB_WIDTH:0]       NON_DEP    = {1'b1, {RoB_WIDTH{1'b0}}};
   localparam logic [QUEUE_DEPTH_LOG:0] FULL_COUNT = {1'b1, {QUEUE_DEPTH_LOG{1'b0}}};

   localparam logic [6:0] OP_LUI   = 7'd1;
   localparam logic [6:0] OP_AUIPC = 7'd2;
   localparam logic [6:0] OP_JAL   = 7'd3;
   localparam logic [6:0] OP_JALR  = 7'd4;
   localparam logic [6:0] OP_BEQ   = 7'd5;
   localparam logic [6:0] OP_BGEU  = 7'd10;
   localparam logic [6:0] OP_LB    = 7'd11;
   localparam logic [6:0] OP_LHU   = 7'd15;
   localparam logic [6:0] OP_SB    = 7'd16;
   localparam logic [6:0] OP_SW    = 7'd18;
   localparam logic [6:0] OP_ADDI  = 7'd19;
   localparam logic [6:0] OP_SRAI  = 7'd27;
   localparam logic [6:0] OP_ADD   = 7'd28;
   localparam logic [6:0] OP_AND   = 7'd37;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [6:0]  opcode;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        predict;
   } entry_t;

   entry_t queue_mem [DEPTH];
   entry_t head_entry;
   entry_t in_entry;

   logic [QUEUE_DEPTH_LOG-1:0] head_ptr_reg;
   logic [QUEUE_DEPTH_LOG-1:0] tail_ptr_reg;
   logic [QUEUE_DEPTH_LOG:0]   count_reg;

   logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_itype, is_rtype;
   logic is_known, needs_rs, needs_lsb, uses_rs1, uses_rs2, writes_rd;
   logic head_valid, issue, pop, push;

   assign head_entry = queue_mem[head_ptr_reg];
   assign in_entry   = '{pc: in_pc, imm: in_imm, opcode: in_opcode, rs1: in_rs1,
                         rs2: in_rs2, rd: in_rd, predict: in_predict};
   assign RF_rs1     = head_entry.rs1;
   assign RF_rs2     = head_entry.rs2;
   assign in_ready   = (count_reg != FULL_COUNT);
   assign head_valid = (count_reg != '0);

   assign is_lui    = head_entry.opcode == OP_LUI;
   assign is_auipc  = head_entry.opcode == OP_AUIPC;
   assign is_jal    = head_entry.opcode == OP_JAL;
   assign is_jalr   = head_entry.opcode == OP_JALR;
   assign is_branch = (head_entry.opcode >= OP_BEQ)  && (head_entry.opcode <= OP_BGEU);
   assign is_load   = (head_entry.opcode >= OP_LB)   && (head_entry.opcode <= OP_LHU);
   assign is_store  = (head_entry.opcode >= OP_SB)   && (head_entry.opcode <= OP_SW);
   assign is_itype  = (head_entry.opcode >= OP_ADDI) && (head_entry.opcode <= OP_SRAI);
   assign is_rtype  = (head_entry.opcode >= OP_ADD)  && (head_entry.opcode <= OP_AND);

   assign needs_rs  = is_jalr || is_branch || is_itype || is_rtype;
   assign needs_lsb = is_load || is_store;
   assign is_known  = is_lui || is_auipc || is_jal || needs_rs || needs_lsb;
   assign uses_rs1  = needs_rs || needs_lsb;
   assign uses_rs2  = is_branch || is_store || is_rtype;
   assign writes_rd = is_known && !is_branch && !is_store && (head_entry.rd != 5'd0);

   // Unknown opcodes need no unit, so they leave the queue as soon as they reach the head.
   assign issue = rdy_in && !flush_signal && head_valid && is_known && !RoB_isFull
                  && !(needs_rs && RS_isFull) && !(needs_lsb && LSB_isFull);
   assign pop   = issue || (rdy_in && !flush_signal && head_valid && !is_known);
   assign push  = !rst_in && rdy_in && !flush_signal && in_valid && in_ready;

   logic [CDB_PORTS-1:0] hit_j, hit_k;
   genvar gi;
   generate
      for (gi = 0; gi < CDB_PORTS; gi++) begin : g_cdb
         assign hit_j[gi] = cdb_valid[gi] && (cdb_tag[gi*RoB_WIDTH +: RoB_WIDTH] == RF_Qj[RoB_WIDTH-1:0]);
         assign hit_k[gi] = cdb_valid[gi] && (cdb_tag[gi*RoB_WIDTH +: RoB_WIDTH] == RF_Qk[RoB_WIDTH-1:0]);
      end
   endgenerate

   logic [31:0] fwd_j_data, fwd_k_data;
   always_comb begin
      fwd_j_data = '0;
      fwd_k_data = '0;
      // Scan downward so the lowest matching channel is the last one written.
      for (int i = CDB_PORTS - 1; i >= 0; i--) begin
         if (hit_j[i]) fwd_j_data = cdb_data[i*32 +: 32];
         if (hit_k[i]) fwd_k_data = cdb_data[i*32 +: 32];
      end
   end

   logic [31:0]      vj_next, vk_next, next_pc_next, ready_data_next, seq_pc, upper_imm;
   logic [RoB_WIDTH:0] qj_next, qk_next;
   always_comb begin
      vj_next = RF_Vj;
      qj_next = RF_Qj;
      vk_next = RF_Vk;
      qk_next = RF_Qk;
      if (!uses_rs1 || head_entry.rs1 == 5'd0) begin
         vj_next = '0;
         qj_next = NON_DEP;
      end else if (RF_Qj != NON_DEP && |hit_j) begin
         vj_next = fwd_j_data;
         qj_next = NON_DEP;
      end
      if (!uses_rs2 || head_entry.rs2 == 5'd0) begin
         vk_next = '0;
         qk_next = NON_DEP;
      end else if (RF_Qk != NON_DEP && |hit_k) begin
         vk_next = fwd_k_data;
         qk_next = NON_DEP;
      end
   end

   always_comb begin
      seq_pc          = head_entry.pc + 32'd4;
      upper_imm       = head_entry.imm << 12;
      next_pc_next    = (is_jal || is_branch) ? head_entry.pc + head_entry.imm : seq_pc;
      ready_data_next = '0;
      if (is_lui)        ready_data_next = upper_imm;
      else if (is_auipc) ready_data_next = head_entry.pc + upper_imm;
      else if (is_jal)   ready_data_next = seq_pc;
   end

   always_ff @(posedge clk_in) begin
      if (push) queue_mem[tail_ptr_reg] <= in_entry;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_ptr_reg      <= '0;
         tail_ptr_reg      <= '0;
         count_reg         <= '0;
         RoB_newEntry_en   <= 1'b0;
         RS_newEntry_en    <= 1'b0;
         LSB_newEntry_en   <= 1'b0;
         RF_newEntry_en    <= 1'b0;
         out_robIndex      <= '0;
         out_opcode        <= '0;
         out_rd            <= '0;
         out_pc            <= '0;
         out_next_pc       <= '0;
         out_imm           <= '0;
         out_Vj            <= '0;
         out_Vk            <= '0;
         out_Qj            <= '0;
         out_Qk            <= '0;
         out_predict       <= 1'b0;
         out_already_ready <= 1'b0;
         out_ready_data    <= '0;
      end else if (!rdy_in) begin
         RoB_newEntry_en <= 1'b0;
         RS_newEntry_en  <= 1'b0;
         LSB_newEntry_en <= 1'b0;
         RF_newEntry_en  <= 1'b0;
      end else if (flush_signal) begin
         head_ptr_reg    <= '0;
         tail_ptr_reg    <= '0;
         count_reg       <= '0;
         RoB_newEntry_en <= 1'b0;
         RS_newEntry_en  <= 1'b0;
         LSB_newEntry_en <= 1'b0;
         RF_newEntry_en  <= 1'b0;
      end else begin
         if (push) tail_ptr_reg <= tail_ptr_reg + 1'b1;
         if (pop)  head_ptr_reg <= head_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         RoB_newEntry_en <= issue;
         RS_newEntry_en  <= issue && needs_rs;
         LSB_newEntry_en <= issue && needs_lsb;
         RF_newEntry_en  <= issue && writes_rd;
         if (issue) begin
            out_robIndex      <= RoB_newEntryIndex;
            out_opcode        <= head_entry.opcode;
            out_rd            <= (is_branch || is_store) ? 5'd0 : head_entry.rd;
            out_pc            <= head_entry.pc;
            out_next_pc       <= next_pc_next;
            out_imm           <= is_rtype ? 32'd0 : head_entry.imm;
            out_Vj            <= vj_next;
            out_Vk            <= vk_next;
            out_Qj            <= qj_next;
            out_Qk            <= qk_next;
            out_predict       <= is_branch && head_entry.predict;
            out_already_ready <= is_lui || is_auipc || is_jal;
            out_ready_data    <= ready_data_next;
         end
      end
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: a vector table of single-instruction issues plus
// hand-written sequences for back-pressure, in-order blocking, flush and pause.
module tb_dispatch_queue;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush_signal, in_valid, in_ready, in_predict;
   logic [31:0] in_pc, in_imm;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rs1, in_rs2, in_rd, RF_rs1, RF_rs2;
   logic [3:0]  RF_Qj, RF_Qk, out_Qj, out_Qk;
   logic [31:0] RF_Vj, RF_Vk;
   logic [1:0]  cdb_valid;
   logic [5:0]  cdb_tag;
   logic [63:0] cdb_data;
   logic        RoB_isFull, RS_isFull, LSB_isFull;
   logic [2:0]  RoB_newEntryIndex, out_robIndex;
   logic        RoB_newEntry_en, RS_newEntry_en, LSB_newEntry_en, RF_newEntry_en;
   logic [6:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [31:0] out_pc, out_next_pc, out_imm, out_Vj, out_Vk, out_ready_data;
   logic        out_predict, out_already_ready;

   int n_checks = 0;
   int n_errors = 0;

   dispatch_queue #(.RoB_WIDTH(3), .QUEUE_DEPTH_LOG(2), .CDB_PORTS(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
      .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_predict(in_predict), .RF_rs1(RF_rs1), .RF_rs2(RF_rs2), .RF_Qj(RF_Qj),
      .RF_Qk(RF_Qk), .RF_Vj(RF_Vj), .RF_Vk(RF_Vk), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .RoB_isFull(RoB_isFull),
      .RS_isFull(RS_isFull), .LSB_isFull(LSB_isFull),
      .RoB_newEntryIndex(RoB_newEntryIndex), .RoB_newEntry_en(RoB_newEntry_en),
      .RS_newEntry_en(RS_newEntry_en), .LSB_newEntry_en(LSB_newEntry_en),
      .RF_newEntry_en(RF_newEntry_en), .out_robIndex(out_robIndex),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_pc(out_pc),
      .out_next_pc(out_next_pc), .out_imm(out_imm), .out_Vj(out_Vj), .out_Vk(out_Vk),
      .out_Qj(out_Qj), .out_Qk(out_Qk), .out_predict(out_predict),
      .out_already_ready(out_already_ready), .out_ready_data(out_ready_data)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc, imm;
      logic        pred;
      logic [3:0]  qj, qk;
      logic [31:0] vj, vk;
      logic [1:0]  cv;
      logic [5:0]  ct;
      logic [63:0] cd;
      logic [2:0]  rob;
      logic [3:0]  e_stb;   // {RoB, RS, LSB, RF}
      logic        chk;
      logic [31:0] e_vj, e_vk;
      logic [3:0]  e_qj, e_qk;
      logic [31:0] e_npc, e_rdata;
      logic        e_ar;
      logic [4:0]  e_rd;
      logic [31:0] e_imm;
      logic        e_pred;
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_stb(input string name, input logic [3:0] exp);
      chk(name, 32'({RoB_newEntry_en, RS_newEntry_en, LSB_newEntry_en, RF_newEntry_en}), 32'(exp));
   endtask

   task automatic push_op(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc);
      in_valid  = 1'b1;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = 5'd1;
      in_rs2    = 5'd2;
      in_pc     = pc;
      in_imm    = 32'd4;
      in_predict = 1'b0;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //         op     rs1   rs2   rd    pc             imm            pr    qj    qk    vj            vk            cv     ct         cd                        rob   stb      chk   e_vj          e_vk          e_qj  e_qk  e_npc          e_rdata        ar    rd    e_imm          pred
      vecs[0]  = '{7'd1,  5'd0, 5'd0, 5'd5, 32'h100,       32'h12345,     1'b0, 4'h8, 4'h8, 32'h0,        32'h0,        2'b00, 6'h00,     64'h0,                    3'd1, 4'b1001, 1'b1, 32'h0,        32'h0,        4'h8, 4'h8, 32'h104,       32'h12345000,  1'b1, 5'd5, 32'h12345,     1'b0};
      vecs[1]  = '{7'd28, 5'd1, 5'd2, 5'd3, 32'h200,       32'h77,        1'b0, 4'h2, 4'h3, 32'h11,       32'h22,       2'b11, 6'b010010, {32'h9, 32'h5},           3'd2, 4'b1101, 1'b1, 32'h5,        32'h22,       4'h8, 4'h3, 32'h204,       32'h0,         1'b0, 5'd3, 32'h0,         1'b0};
      vecs[2]  = '{7'd28, 5'd1, 5'd2, 5'd4, 32'h210,       32'h0,         1'b0, 4'h8, 4'h5, 32'hAA,       32'h33,       2'b11, 6'b101000, {32'h99, 32'h55},         3'd3, 4'b1101, 1'b1, 32'hAA,       32'h99,       4'h8, 4'h8, 32'h214,       32'h0,         1'b0, 5'd4, 32'h0,         1'b0};
      vecs[3]  = '{7'd5,  5'd1, 5'd2, 5'd7, 32'hFFFFFFF8,  32'h10,        1'b1, 4'h8, 4'h4, 32'h1,        32'h2,        2'b00, 6'h00,     64'h0,                    3'd4, 4'b1100, 1'b1, 32'h1,        32'h2,        4'h8, 4'h4, 32'h8,         32'h0,         1'b0, 5'd0, 32'h10,        1'b1};
      vecs[4]  = '{7'd19, 5'd1, 5'd9, 5'd0, 32'h300,       32'h5,         1'b1, 4'h1, 4'h2, 32'h40,       32'h33,       2'b00, 6'h00,     64'h0,                    3'd5, 4'b1100, 1'b1, 32'h40,       32'h0,        4'h1, 4'h8, 32'h304,       32'h0,         1'b0, 5'd0, 32'h5,         1'b0};
      vecs[5]  = '{7'd50, 5'd1, 5'd2, 5'd3, 32'h350,       32'h0,         1'b0, 4'h8, 4'h8, 32'h0,        32'h0,        2'b00, 6'h00,     64'h0,                    3'd0, 4'b0000, 1'b0, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,         32'h0,         1'b0, 5'd0, 32'h0,         1'b0};
      vecs[6]  = '{7'd18, 5'd2, 5'd3, 5'd9, 32'h400,       32'hC,         1'b0, 4'h8, 4'h8, 32'h1000,     32'h5,        2'b00, 6'h00,     64'h0,                    3'd6, 4'b1010, 1'b1, 32'h1000,     32'h5,        4'h8, 4'h8, 32'h404,       32'h0,         1'b0, 5'd0, 32'hC,         1'b0};
      vecs[7]  = '{7'd3,  5'd0, 5'd0, 5'd1, 32'h500,       32'hFFFFFFF0,  1'b0, 4'h8, 4'h8, 32'h0,        32'h0,        2'b00, 6'h00,     64'h0,                    3'd7, 4'b1001, 1'b1, 32'h0,        32'h0,        4'h8, 4'h8, 32'h4F0,       32'h504,       1'b1, 5'd1, 32'hFFFFFFF0,  1'b0};
      vecs[8]  = '{7'd2,  5'd0, 5'd0, 5'd2, 32'h1000,      32'h1,         1'b0, 4'h8, 4'h8, 32'h0,        32'h0,        2'b00, 6'h00,     64'h0,                    3'd0, 4'b1001, 1'b1, 32'h0,        32'h0,        4'h8, 4'h8, 32'h1004,      32'h2000,      1'b1, 5'd2, 32'h1,         1'b0};
      vecs[9]  = '{7'd13, 5'd5, 5'd0, 5'd6, 32'h600,       32'h8,         1'b0, 4'h3, 4'h8, 32'h77,       32'h0,        2'b01, 6'b000011, {32'h0, 32'h700},         3'd1, 4'b1011, 1'b1, 32'h700,      32'h0,        4'h8, 4'h8, 32'h604,       32'h0,         1'b0, 5'd6, 32'h8,         1'b0};
      vecs[10] = '{7'd4,  5'd1, 5'd0, 5'd1, 32'h700,       32'h4,         1'b0, 4'h8, 4'h8, 32'h123,      32'h0,        2'b00, 6'h00,     64'h0,                    3'd2, 4'b1101, 1'b1, 32'h123,      32'h0,        4'h8, 4'h8, 32'h704,       32'h0,         1'b0, 5'd1, 32'h4,         1'b0};

      rst_in = 1'b1; rdy_in = 1'b1; flush_signal = 1'b0; in_valid = 1'b0;
      in_pc = '0; in_imm = '0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_predict = 1'b0;
      RF_Qj = 4'h8; RF_Qk = 4'h8; RF_Vj = '0; RF_Vk = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
      RoB_isFull = 1'b0; RS_isFull = 1'b0; LSB_isFull = 1'b0; RoB_newEntryIndex = '0;
      step(); step();
      rst_in = 1'b0;

      chk_stb("reset strobes", 4'b0000);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset already_ready", 32'(out_already_ready), 32'd0);
      chk("reset ready_data", out_ready_data, 32'h0);
      chk("reset next_pc", out_next_pc, 32'h0);
      chk("reset Qj", 32'(out_Qj), 32'h0);

      // Fill with RS blocked, then drain in order.
      RS_isFull = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_op(7'd19, 5'(k + 1), 32'h10 + 32'(4 * k));
         chk("fill in_ready", 32'(in_ready), 32'(k < 3));
         chk_stb("fill strobes", 4'b0000);
      end
      RS_isFull = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_stb("drain strobes", 4'b1101);
         chk("drain pc", out_pc, 32'h10 + 32'(4 * k));
         chk("drain in_ready", 32'(in_ready), 32'd1);
      end
      step();
      chk_stb("drain idle", 4'b0000);

      // Head lw blocked on LSB holds back a younger add.
      LSB_isFull = 1'b1;
      push_op(7'd13, 5'd6, 32'h20);
      chk_stb("lw push", 4'b0000);
      push_op(7'd28, 5'd7, 32'h24);
      chk_stb("add behind lw", 4'b0000);
      step();
      chk_stb("still blocked", 4'b0000);
      LSB_isFull = 1'b0;
      step();
      chk_stb("lw issue", 4'b1011);
      chk("lw opcode", 32'(out_opcode), 32'd13);
      step();
      chk_stb("add issue", 4'b1101);
      chk("add opcode", 32'(out_opcode), 32'd28);
      step();
      chk_stb("order idle", 4'b0000);

      // Flush discards queued entries and the one offered alongside it.
      RS_isFull = 1'b1;
      for (int k = 0; k < 3; k++) push_op(7'd19, 5'd1, 32'h30 + 32'(4 * k));
      in_valid = 1'b1; in_opcode = 7'd19; in_pc = 32'h3C; flush_signal = 1'b1;
      step();
      in_valid = 1'b0; flush_signal = 1'b0;
      chk_stb("flush strobes", 4'b0000);
      chk("flush in_ready", 32'(in_ready), 32'd1);
      RS_isFull = 1'b0;
      step();
      chk_stb("post flush 1", 4'b0000);
      step();
      chk_stb("post flush 2", 4'b0000);

      // Pause holds state and ignores offered input.
      RS_isFull = 1'b1;
      push_op(7'd19, 5'd1, 32'hA0);
      push_op(7'd19, 5'd2, 32'hA4);
      rdy_in = 1'b0; RS_isFull = 1'b0;
      in_valid = 1'b1; in_opcode = 7'd19; in_pc = 32'hEE;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_stb("pause strobes", 4'b0000);
         chk("pause in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0; rdy_in = 1'b1;
      step();
      chk_stb("resume 1", 4'b1101);
      chk("resume pc 1", out_pc, 32'hA0);
      step();
      chk_stb("resume 2", 4'b1101);
      chk("resume pc 2", out_pc, 32'hA4);
      step();
      chk_stb("resume idle", 4'b0000);

      // Table: push one instruction, present RF/CDB while it is head, check the issue.
      for (int k = 0; k < 11; k++) begin
         in_valid = 1'b1; in_opcode = vecs[k].op; in_rs1 = vecs[k].rs1; in_rs2 = vecs[k].rs2;
         in_rd = vecs[k].rd; in_pc = vecs[k].pc; in_imm = vecs[k].imm; in_predict = vecs[k].pred;
         step();
         in_valid = 1'b0;
         RF_Qj = vecs[k].qj; RF_Qk = vecs[k].qk; RF_Vj = vecs[k].vj; RF_Vk = vecs[k].vk;
         cdb_valid = vecs[k].cv; cdb_tag = vecs[k].ct; cdb_data = vecs[k].cd;
         RoB_newEntryIndex = vecs[k].rob;
         #1;
         chk($sformatf("v%0d RF_rs1", k), 32'(RF_rs1), 32'(vecs[k].rs1));
         step();
         chk_stb($sformatf("v%0d strobes", k), vecs[k].e_stb);
         if (vecs[k].chk) begin
            chk($sformatf("v%0d robIndex", k), 32'(out_robIndex), 32'(vecs[k].rob));
            chk($sformatf("v%0d opcode", k), 32'(out_opcode), 32'(vecs[k].op));
            chk($sformatf("v%0d pc", k), out_pc, vecs[k].pc);
            chk($sformatf("v%0d Vj", k), out_Vj, vecs[k].e_vj);
            chk($sformatf("v%0d Vk", k), out_Vk, vecs[k].e_vk);
            chk($sformatf("v%0d Qj", k), 32'(out_Qj), 32'(vecs[k].e_qj));
            chk($sformatf("v%0d Qk", k), 32'(out_Qk), 32'(vecs[k].e_qk));
            chk($sformatf("v%0d next_pc", k), out_next_pc, vecs[k].e_npc);
            chk($sformatf("v%0d ready_data", k), out_ready_data, vecs[k].e_rdata);
            chk($sformatf("v%0d already_ready", k), 32'(out_already_ready), 32'(vecs[k].e_ar));
            chk($sformatf("v%0d rd", k), 32'(out_rd), 32'(vecs[k].e_rd));
            chk($sformatf("v%0d imm", k), out_imm, vecs[k].e_imm);
            chk($sformatf("v%0d predict", k), 32'(out_predict), 32'(vecs[k].e_pred));
         end
         cdb_valid = '0; RF_Qj = 4'h8; RF_Qk = 4'h8;
         step();
         chk_stb($sformatf("v%0d idle", k), 4'b0000);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
